nbr_scan_ctrl: RTL and testbench

Sequencer that accepts one event coordinate (x,y) per transaction and walks its (2*RADIUS+1)^2 neighbour window in a fixed order. It discards out-of-frame candidates and the centre pixel, and issues each valid neighbour's linear pixel address to the pixel/feature memory over a valid/ready request port. It sits between the event input FIFO and the graph-build memory read path. It signals completion with a one-cycle done pulse and a neighbour count.

---
 rtl/nbr_scan_ctrl_pkg.sv | 20 ++
 rtl/nbr_scan_ctrl_if.sv | 19 +
 rtl/nbr_cand_gen.sv | 28 ++
 rtl/nbr_scan_ctrl.sv | 96 +++++++++
 tb/tb_nbr_scan_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/nbr_scan_ctrl_pkg.sv
// Shared frame geometry, index/address types and scan state encoding for the
// neighbour scan controller.
package nbr_scan_ctrl_pkg;
    localparam int IMG_W  = 120;
    localparam int IMG_H  = 100;
    localparam int RADIUS = 2;
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int CNT_W  = $clog2((2 * RADIUS + 1) ** 2);
    localparam int X_W    = $clog2(IMG_W);
    localparam int Y_W    = $clog2(IMG_H);
    // Signed offset wide enough for -RADIUS..+RADIUS.
    localparam int OFF_W  = $clog2(RADIUS + 1) + 1;

    typedef logic [X_W-1:0]           x_idx_t;
    typedef logic [Y_W-1:0]           y_idx_t;
    typedef logic [ADDR_W-1:0]        nbr_addr_t;
    typedef logic signed [OFF_W-1:0]  off_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} nbr_scan_state_e;
endpackage

// File: rtl/nbr_scan_ctrl_if.sv
// Event-input and memory-request handshakes of the neighbour scan controller.
interface nbr_scan_ctrl_if;
    logic                         ev_valid;
    logic                         ev_ready;
    nbr_scan_ctrl_pkg::x_idx_t    ev_x;
    nbr_scan_ctrl_pkg::y_idx_t    ev_y;
    logic                         mem_req_valid;
    logic                         mem_req_ready;
    nbr_scan_ctrl_pkg::nbr_addr_t mem_req_addr;

    modport master (
        input  ev_valid, ev_x, ev_y, mem_req_ready,
        output ev_ready, mem_req_valid, mem_req_addr
    );
    modport slave (
        output ev_valid, ev_x, ev_y, mem_req_ready,
        input  ev_ready, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/nbr_cand_gen.sv
// Combinational neighbour candidate: frame bounds + centre exclusion and the
// linear address ny*IMG_W+nx.
module nbr_cand_gen
    import nbr_scan_ctrl_pkg::*;
(
    input  x_idx_t    x,
    input  y_idx_t    y,
    input  off_t      dx,
    input  off_t      dy,
    output logic      cand_valid,
    output nbr_addr_t cand_addr
);
    localparam logic signed [X_W:0] XLIM = (X_W + 1)'(IMG_W);
    localparam logic signed [Y_W:0] YLIM = (Y_W + 1)'(IMG_H);

    logic signed [X_W:0] nx;
    logic signed [Y_W:0] ny;

    assign nx = $signed({1'b0, x}) + $signed({{(X_W + 1 - OFF_W){dx[OFF_W-1]}}, dx});
    assign ny = $signed({1'b0, y}) + $signed({{(Y_W + 1 - OFF_W){dy[OFF_W-1]}}, dy});

    assign cand_valid = !nx[X_W] && (nx < XLIM) &&
                        !ny[Y_W] && (ny < YLIM) &&
                        !(dx == '0 && dy == '0);

    assign cand_addr = nbr_addr_t'(ny[Y_W-1:0]) * nbr_addr_t'(IMG_W)
                     + nbr_addr_t'(nx[X_W-1:0]);
endmodule

// File: rtl/nbr_scan_ctrl.sv
// Walks the (2R+1)^2 window around one event coordinate and issues each valid
// neighbour's pixel address; ends with a one-cycle done pulse and count.
module nbr_scan_ctrl
    import nbr_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    nbr_scan_ctrl_if.master  bus,
    output logic             busy,
    output logic             scan_done,
    output logic             scan_err,
    output logic [CNT_W-1:0] nb_count
);
    localparam off_t OFF_MIN = off_t'(-RADIUS);
    localparam off_t OFF_MAX = off_t'(RADIUS);

    nbr_scan_state_e  state;
    x_idx_t           x_q;
    y_idx_t           y_q;
    off_t             dx, dy;
    logic [CNT_W-1:0] count;
    logic             err;
    logic             cand_valid;
    nbr_addr_t        cand_addr;

    nbr_cand_gen u_cand (
        .x          (x_q),
        .y          (y_q),
        .dx         (dx),
        .dy         (dy),
        .cand_valid (cand_valid),
        .cand_addr  (cand_addr)
    );

    // flush masks acceptance so an abort never overlaps a new event.
    assign bus.ev_ready      = (state == IDLE) && !flush;
    assign bus.mem_req_valid = (state == SCAN) && cand_valid;
    assign bus.mem_req_addr  = bus.mem_req_valid ? cand_addr : '0;
    assign busy              = (state != IDLE);
    assign scan_done         = (state == DONE);
    assign scan_err          = (state == DONE) && err;
    assign nb_count          = (state == DONE) ? count : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x_q   <= '0;
            y_q   <= '0;
            dx    <= '0;
            dy    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ev_valid) begin
                        x_q   <= bus.ev_x;
                        y_q   <= bus.ev_y;
                        dx    <= OFF_MIN;
                        dy    <= OFF_MIN;
                        count <= '0;
                        // Off-frame events finish immediately with an error.
                        if (bus.ev_x >= x_idx_t'(IMG_W) || bus.ev_y >= y_idx_t'(IMG_H)) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    // Invalid candidates advance unconditionally; valid ones wait for ready.
                    if (!cand_valid || bus.mem_req_ready) begin
                        if (cand_valid)
                            count <= count + CNT_W'(1);
                        if (dx == OFF_MAX) begin
                            dx <= OFF_MIN;
                            if (dy == OFF_MAX)
                                state <= DONE;
                            else
                                dy <= dy + off_t'(1);
                        end else begin
                            dx <= dx + off_t'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nbr_scan_ctrl.sv
// Self-checking bench for nbr_scan_ctrl: directed table, randomized events
// against a window-enumeration model, and flush/reset abort sequences.
module tb_nbr_scan_ctrl;
    import nbr_scan_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic             busy, scan_done, scan_err;
    logic [CNT_W-1:0] nb_count;

    nbr_scan_ctrl_if bus ();

    nbr_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.master),
        .busy      (busy),
        .scan_done (scan_done),
        .scan_err  (scan_err),
        .nb_count  (nb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int mode;       // 0: ready high, 1: ready toggles, 2: random ready
        int exp_first;
        int exp_last;
    } vec_t;

    int errs = 0;
    int checks = 0;
    int got_q[$];
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: enumerate the window directly from the frame rules.
    function automatic void model(input int x, input int y);
        exp_q.delete();
        if (x >= IMG_W || y >= IMG_H) return;
        for (int oy = -RADIUS; oy <= RADIUS; oy++)
            for (int ox = -RADIUS; ox <= RADIUS; ox++) begin
                int nx = x + ox;
                int ny = y + oy;
                if (nx >= 0 && nx < IMG_W && ny >= 0 && ny < IMG_H && !(ox == 0 && oy == 0))
                    exp_q.push_back(ny * IMG_W + nx);
            end
    endfunction

    task automatic run_event(input int x, input int y, input int mode,
                             output int lat, output int cnt, output int err, output int stalls);
        bit prev_stall = 0;
        int prev_addr = 0;
        got_q.delete();
        stalls = 0; lat = -1; cnt = -1; err = -1;
        @(negedge clk);
        bus.ev_valid = 1'b1; bus.ev_x = x_idx_t'(x); bus.ev_y = y_idx_t'(y);
        bus.mem_req_ready = 1'b0;
        #1 chk("ev_ready at accept", int'(bus.ev_ready), 1);
        for (int cyc = 1; cyc < 300 && lat < 0; cyc++) begin
            @(negedge clk);
            bus.ev_valid = 1'b0;
            case (mode)
                0:       bus.mem_req_ready = 1'b1;
                1:       bus.mem_req_ready = (cyc % 2 == 0);
                default: bus.mem_req_ready = ($urandom % 3 != 0);
            endcase
            #1;
            if (prev_stall)
                chk("addr held during stall",
                    bus.mem_req_valid ? int'(bus.mem_req_addr) : -1, prev_addr);
            prev_stall = 0;
            if (bus.mem_req_valid) begin
                chk("addr inside frame", int'(bus.mem_req_addr) < IMG_W * IMG_H, 1);
                if (bus.mem_req_ready) got_q.push_back(int'(bus.mem_req_addr));
                else begin
                    stalls++; prev_stall = 1; prev_addr = int'(bus.mem_req_addr);
                end
            end
            if (scan_done) begin
                lat = cyc; cnt = int'(nb_count); err = int'(scan_err);
            end
        end
        bus.mem_req_ready = 1'b0;
        if (lat < 0) chk("scan_done within cycle budget", 0, 1);
    endtask

    task automatic check_run(input vec_t v, input bit use_ends);
        int lat, cnt, err, stalls, mism;
        bit oob;
        oob = (v.x >= IMG_W || v.y >= IMG_H);
        run_event(v.x, v.y, v.mode, lat, cnt, err, stalls);
        model(v.x, v.y);
        chk($sformatf("(%0d,%0d) nb_count", v.x, v.y), cnt, exp_q.size());
        chk($sformatf("(%0d,%0d) requests issued", v.x, v.y), got_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) mism++;
        chk($sformatf("(%0d,%0d) addr order mismatches", v.x, v.y), mism, 0);
        chk($sformatf("(%0d,%0d) scan_err", v.x, v.y), err, int'(oob));
        chk($sformatf("(%0d,%0d) done latency", v.x, v.y), lat,
            oob ? 1 : 1 + (2 * RADIUS + 1) ** 2 + stalls);
        if (use_ends && got_q.size() > 0) begin
            chk($sformatf("(%0d,%0d) first addr", v.x, v.y), got_q[0], v.exp_first);
            chk($sformatf("(%0d,%0d) last addr", v.x, v.y), got_q[got_q.size()-1], v.exp_last);
        end
        @(negedge clk);
        #1 chk($sformatf("(%0d,%0d) ev_ready after done", v.x, v.y), int'(bus.ev_ready), 1);
    endtask

    task automatic abort_test(input bit use_rst);
        string tag;
        int hs = 0;
        bit seen = 0;
        bit saw_done = 0;
        tag = use_rst ? "rst" : "flush";
        @(negedge clk);
        bus.ev_valid = 1'b1; bus.ev_x = x_idx_t'(12); bus.ev_y = y_idx_t'(25);
        for (int cyc = 1; cyc < 100 && !seen; cyc++) begin
            @(negedge clk);
            bus.ev_valid = 1'b0;
            bus.mem_req_ready = (hs < 4);
            #1;
            if (scan_done) saw_done = 1;
            if (bus.mem_req_valid && bus.mem_req_ready) hs++;
            else if (bus.mem_req_valid && hs == 4) seen = 1;
        end
        chk({tag, ": 5th request reached"}, int'(seen), 1);
        @(negedge clk);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        bus.ev_valid = 1'b1; bus.ev_x = x_idx_t'(30); bus.ev_y = y_idx_t'(40);
        #1 chk({tag, ": ev_ready masked during abort"}, int'(bus.ev_ready), 0);
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        #1;
        chk({tag, ": mem_req_valid after abort"}, int'(bus.mem_req_valid), 0);
        chk({tag, ": busy after abort"}, int'(busy), 0);
        chk({tag, ": scan_done after abort"}, int'(scan_done | saw_done), 0);
        chk({tag, ": scan_err after abort"}, int'(scan_err), 0);
        chk({tag, ": nb_count after abort"}, int'(nb_count), 0);
        chk({tag, ": mem_req_addr after abort"}, int'(bus.mem_req_addr), 0);
        chk({tag, ": ev_ready first idle cycle"}, int'(bus.ev_ready), 1);
        @(negedge clk);
        bus.ev_valid = 1'b0;
        #1 chk({tag, ": event accepted after abort"}, int'(busy), 1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1 chk({tag, ": cleanup flush idles"}, int'(busy), 0);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{x: 12,  y: 25, mode: 0, exp_first: 2770,  exp_last: 3254};
        tbl[1] = '{x: 119, y: 99, mode: 0, exp_first: 11757, exp_last: 11998};
        tbl[2] = '{x: 0,   y: 0,  mode: 0, exp_first: 1,     exp_last: 242};
        tbl[3] = '{x: 12,  y: 25, mode: 1, exp_first: 2770,  exp_last: 3254};
        tbl[4] = '{x: 120, y: 99, mode: 0, exp_first: 0,     exp_last: 0};

        rst = 1'b1; flush = 1'b0;
        bus.ev_valid = 1'b0; bus.ev_x = '0; bus.ev_y = '0; bus.mem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset ev_ready", int'(bus.ev_ready), 1);
        chk("reset mem_req_valid", int'(bus.mem_req_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset scan_done", int'(scan_done), 0);
        chk("reset scan_err", int'(scan_err), 0);
        chk("reset nb_count", int'(nb_count), 0);
        chk("reset mem_req_addr", int'(bus.mem_req_addr), 0);

        for (int i = 0; i < 5; i++) check_run(tbl[i], 1'b1);

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v.x = int'($urandom_range(0, IMG_W + 3));
            v.y = int'($urandom_range(0, IMG_H + 3));
            v.mode = int'($urandom_range(0, 2));
            v.exp_first = 0; v.exp_last = 0;
            check_run(v, 1'b0);
        end

        abort_test(1'b0);
        abort_test(1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
